// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared state encodings, handshake values and widths for div_unit
package div_unit_pkg;

    localparam int DATA_W = 32;
    localparam int RES_W  = 64;
    localparam int CNT_W  = 5;

    // Last step index; with the counter starting at 0 this is the 32nd step.
    localparam logic [CNT_W-1:0] LAST_STEP = 5'd31;

    localparam logic RESULT_READY     = 1'b1;
    localparam logic RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit multi-cycle restoring divider (signed/unsigned) for the EX stage
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   signed_div_i 1 = signed divide, 0 = unsigned
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      divide request, held until ready_o
//   annul_i      cancel from pipeline flush (wins over start_i)
//   result_o     {remainder, quotient}, registered
//   ready_o      result_o valid, registered
//   stall_req_o  EX-stage stall request, combinational
module div_unit
    import div_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [RES_W-1:0]  result_o,
    output logic              ready_o,
    output logic              stall_req_o
);

    div_state_e        state_q;
    div_state_e        state_d;

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] divisor_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic [DATA_W-1:0] op1_abs;
    logic [DATA_W-1:0] op2_abs;
    logic [DATA_W:0]   step_shift;
    logic [DATA_W:0]   step_diff;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    assign accept = (start_i == DIV_START) && !annul_i;

    assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Partial remainder is always below the divisor, so the shifted value
    // fits in 33 bits and bit 32 of the difference is a clean borrow flag.
    assign step_shift = {rem_q, quo_q[DATA_W-1]};
    assign step_diff  = step_shift - {1'b0, divisor_q};

    assign quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

    assign stall_req_o = rst & start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FREE: begin
                if (accept) begin
                    state_d = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                state_d = annul_i ? ST_FREE : ST_END;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_FREE;
                end else if (cnt_q == LAST_STEP) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                if (start_i == DIV_STOP) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_o  <= '0;
            ready_o   <= RESULT_NOT_READY;
        end else begin
            case (state_q)
                ST_FREE: begin
                    result_o <= '0;
                    ready_o  <= RESULT_NOT_READY;
                    if (accept) begin
                        rem_q     <= '0;
                        quo_q     <= op1_abs;
                        divisor_q <= op2_abs;
                        neg_quo_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem_q <= signed_div_i & opdata1_i[DATA_W-1];
                        cnt_q     <= '0;
                    end
                end
                ST_BYZERO: begin
                    // Zero the working set so END emits an all-zero result.
                    if (!annul_i) begin
                        rem_q     <= '0;
                        quo_q     <= '0;
                        neg_quo_q <= 1'b0;
                        neg_rem_q <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (!annul_i) begin
                        if (step_diff[DATA_W]) begin
                            rem_q <= step_shift[DATA_W-1:0];
                        end else begin
                            rem_q <= step_diff[DATA_W-1:0];
                        end
                        quo_q <= {quo_q[DATA_W-2:0], ~step_diff[DATA_W]};
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_END: begin
                    if (start_i == DIV_START) begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= RESULT_READY;
                    end else begin
                        result_o <= '0;
                        ready_o  <= RESULT_NOT_READY;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= RESULT_NOT_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking scoreboard bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int n_cmp;
    int n_fail;
    logic [63:0] sb_q[$];

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stall_req_o  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Entered and left 1 time unit after a falling edge.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input bit blk,
                           input string name);
        int          cyc;
        int          stall_err;
        bit          done;
        logic [63:0] want;
        sb_q.push_back(exp);
        cyc = 0;
        stall_err = 0;
        done = 0;
        signed_div = s;
        op1 = a;
        op2 = b;
        start = 1'b1;
        annul = blk;
        #1;
        if (stall !== ~blk) stall_err++;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (blk && cyc == 1) annul = 1'b0;
            if (cyc >= (blk ? 2 : 1)) begin
                op1 = $urandom;
                op2 = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
            #1;
            if (ready === 1'b1) done = 1;
            else if (stall !== 1'b1) stall_err++;
        end
        want = sb_q.pop_front();
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: ready not seen after %0d cycles, required within 100", name, cyc);
        end else begin
            if (result !== want) begin
                n_fail++;
                $display("FAIL %s result: got %h required %h", name, result, want);
            end
            n_cmp++;
            if (cyc !== exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d required %0d", name, cyc, exp_lat);
            end
            n_cmp++;
            if (stall_err != 0 || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall: %0d bad cycles, stall at ready %b required 0", name, stall_err, stall);
            end
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_fail++;
            $display("FAIL %s release: ready %b result %h required 0 and 0", name, ready, result);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        annul = 1'b0;
        signed_div = 1'b0;
        op1 = 32'd100;
        op2 = 32'd7;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready %b result %h stall %b required 0 0 0", ready, result, stall);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 0, "udiv_100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0, "sdiv_m7_2");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0, "sdiv_min_m1");
        run_div(1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 34, 0, "udiv_max_1");
        run_div(1'b0, 32'h3, 32'h80000000, {32'h3, 32'h0}, 34, 0, "udiv_small_big");
    endtask

    task automatic test_div_zero();
        run_div(1'b0, 32'd5, 32'd0, 64'd0, 3, 0, "div_zero_u");
        run_div(1'b1, 32'hFFFF0000, 32'd0, 64'd0, 3, 0, "div_zero_s");
    endtask

    task automatic test_annul();
        int rdy_seen;
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        annul = 1'b0;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_stall: got %b required 0", stall);
        end
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready !== 1'b0) rdy_seen++;
        end
        n_cmp++;
        if (rdy_seen != 0) begin
            n_fail++;
            $display("FAIL annul_no_ready: ready high %0d cycles, required 0", rdy_seen);
        end
        #1;
        run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34, 0, "after_annul_50_5");
        run_div(1'b0, 32'd77, 32'd8, {32'd5, 32'd9}, 35, 1, "annul_in_free");
    endtask

    task automatic test_reset_mid();
        signed_div = 1'b0;
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        annul = 1'b0;
        repeat (34) @(negedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1 || result !== {32'h2, 32'hE}) begin
            n_fail++;
            $display("FAIL end_hold: ready %b result %h required 1 %h", ready, result, {32'h2, 32'hE});
        end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_end: ready %b result %h stall %b required 0 0 0", ready, result, stall);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        op1 = 32'd1000;
        op2 = 32'd7;
        start = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_on: ready %b result %h stall %b required 0 0 0", ready, result, stall);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0, "after_reset_9_3");
    endtask

    task automatic test_back_to_back();
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            s = 1'(i % 2);
            a = $urandom;
            b = (i == 4) ? 32'hFFFFFFFF : ($urandom >> (i % 28));
            if (b == 32'd0) b = 32'd13;
            run_div(s, a, b, model(s, a, b), 34, 0, "back_to_back");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset).
REQ-003 The module SHALL have port signed_div_i, input, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-004 The module SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-005 The module SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-006 The module SHALL have port start_i, input, 1 bit: divide request from the EX stage, held high until ready_o is seen.
REQ-007 The module SHALL have port annul_i, input, 1 bit: cancel request, driven by the pipeline flush.
REQ-008 The module SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}.
REQ-009 The module SHALL have port ready_o, output, 1 bit: result_o valid.
REQ-010 The module SHALL have port stall_req_o, output, 1 bit: stall request toward the pipeline controller; drives its EX-stage stall input.

Function
REQ-011 The module SHALL implement the states FREE, BYZERO, ON and END.
REQ-012 In FREE, start_i=1 and annul_i=0 at edge E0 SHALL capture the operands and mode, then move to BYZERO if opdata2_i==0, otherwise to ON with the step counter at 0.
REQ-013 In ON, each edge SHALL perform one restoring shift-subtract step, giving 32 steps on edges E1..E32; at E32 the state SHALL move to END.
REQ-014 In END, the module SHALL register result_o and set ready_o=1 at E33, and hold both while start_i=1.
REQ-015 In END, start_i=0 SHALL return the state to FREE with ready_o=0 and result_o=0 on the same edge.
REQ-016 In BYZERO, the next edge SHALL move the state to END with a zero result; ready_o=1 and result_o=0 from E2.
REQ-017 Signed mode SHALL divide absolute values (two's-complement negation of negative operands).
REQ-018 In signed mode, the quotient SHALL be negated when the operand signs differ.
REQ-019 In signed mode, the remainder SHALL be negated when the dividend is negative.
REQ-020 Unsigned mode SHALL use the operands unmodified.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (natural wrap, no trap).
REQ-022 annul_i=1 in ON or BYZERO SHALL return the state to FREE on the next edge; ready_o stays 0 and no result is produced.
REQ-023 annul_i=1 in FREE SHALL block acceptance of start_i on that edge.
REQ-024 annul_i has priority over start_i.
REQ-025 start_i=1 in ON or BYZERO SHALL be ignored.
REQ-026 Operand or mode changes after E0 SHALL have no effect on the result.
REQ-027 stall_req_o SHALL equal start_i & ~ready_o & ~annul_i, combinational, so the EX stage stalls from the request cycle through E32.
REQ-028 The module SHALL make back-to-back divides possible: start_i low for one cycle after END, then high again in FREE, starts a new divide.

Reset
REQ-029 While rst=0, the state SHALL be FREE, ready_o=0, result_o=0, and all working registers and the counter SHALL be 0, regardless of clk.
REQ-030 Reset asserted mid-ON SHALL abandon the operation immediately; after release the unit SHALL accept a new start_i on the first edge.
REQ-031 stall_req_o SHALL be forced to 0 while rst=0.

Structure
REQ-032 The state encodings (FREE, BYZERO, ON, END), the result-ready and start/stop values, and the 32/64-bit width macros SHALL live in the shared define file; the module SHALL contain no literal state codes.
REQ-033 The module SHALL be a single module with no sub-module; the one-bit subtract step SHALL be an internal 33-bit subtraction.
REQ-034 The implementation SHALL be synthesizable with registered result_o and ready_o, and no latches.

Verification
REQ-035 Unsigned 100/7 with start at E0 SHALL give ready_o=1 at E33 with result_o={0x00000002,0x0000000E}, and stall_req_o=1 from E0 through E32.
REQ-036 Signed -7/2 (0xFFFFFFF9/0x00000002) SHALL give quotient 0xFFFFFFFD and remainder 0xFFFFFFFF.
REQ-037 Signed 0x80000000/0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0; unsigned 0xFFFFFFFF/1 SHALL give quotient 0xFFFFFFFF and remainder 0.
REQ-038 Divisor 0 SHALL give ready_o=1 at E2 with result_o=0; dropping start_i then SHALL return the state to FREE and ready_o to 0.
REQ-039 annul_i pulsed at E10 during ON SHALL put the state in FREE after E10 with ready_o never asserted; a new 50/5 divide SHALL then return {0,10}.
REQ-040 rst driven low between edges mid-ON SHALL clear result_o and ready_o without a clock edge; after release, 9/3 SHALL return {0,3}.
